// File: rtl/dma_pkg.sv
// Shared AXI codes, burst limits and FSM encoding for the DMA engines.
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned MAX_BURST   = 16;
    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } dma_state_e;

    // Zero or anything above the AXI3 INCR limit means "use the maximum".
    function automatic logic [4:0] clamp_burst(input logic [4:0] burst);
        if (burst == 5'd0 || burst > 5'(MAX_BURST)) begin
            return 5'(MAX_BURST);
        end
        return burst;
    endfunction

endpackage

// File: rtl/dma_burst_len.sv
// Registered burst length: min(max burst, words remaining, words left before the next 4 KB page).
module dma_burst_len
    import dma_pkg::*;
#(
    parameter int unsigned DataBits   = 64,
    parameter int unsigned LengthBits = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calc,
    input  logic [11:0]           addr_lo,
    input  logic [LengthBits-1:0] remain,
    input  logic [4:0]            burst,
    output logic [4:0]            blen
);

    localparam int unsigned SizeLog2 = $clog2(DataBits / 8);

    logic [4:0]  blen_q, blen_d;
    logic [12:0] bytes_to_4k;
    logic [12:0] words_to_4k;

    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
        words_to_4k = bytes_to_4k >> SizeLog2;
        blen_d      = blen_q;
        if (calc) begin
            blen_d = burst;
            if (32'(remain) < 32'(blen_d)) begin
                blen_d = 5'(remain);
            end
            if (32'(words_to_4k) < 32'(blen_d)) begin
                blen_d = 5'(words_to_4k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blen_q <= '0;
        end else begin
            blen_q <= blen_d;
        end
    end

    assign blen = blen_q;

endmodule

// File: rtl/dma_writer.sv
// AXI3 write-master: drains a stream FIFO to memory as 4 KB-safe INCR bursts, one burst in flight.
module dma_writer
    import dma_pkg::*;
#(
    parameter int unsigned DataBits     = 64,
    parameter int unsigned AddrBits     = 32,
    parameter int unsigned LengthBits   = 16,
    parameter int unsigned FifoUsedBits = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddrBits-1:0]     cfg_dest,
    input  logic [LengthBits-1:0]   cfg_len,
    input  logic [4:0]              cfg_burst,
    input  logic                    cfg_valid,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic [LengthBits-1:0]   cfg_remain,
    output logic [1:0]              cfg_err,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [DataBits-1:0]     din_data,
    input  logic [FifoUsedBits-1:0] din_fifo_used,
    output logic                    mst_awvalid,
    input  logic                    mst_awready,
    output logic [3:0]              mst_awid,
    output logic [AddrBits-1:0]     mst_awaddr,
    output logic [3:0]              mst_awlen,
    output logic [2:0]              mst_awsize,
    output logic [1:0]              mst_awburst,
    output logic [1:0]              mst_awlock,
    output logic                    mst_wvalid,
    input  logic                    mst_wready,
    output logic [3:0]              mst_wid,
    output logic [DataBits-1:0]     mst_wdata,
    output logic [DataBits/8-1:0]   mst_wstrb,
    output logic                    mst_wlast,
    input  logic                    mst_bvalid,
    output logic                    mst_bready,
    input  logic [3:0]              mst_bid,
    input  logic [1:0]              mst_bresp
);

    localparam int unsigned SizeLog2 = $clog2(DataBits / 8);

    dma_state_e            state_q, state_d;
    logic [AddrBits-1:0]   addr_q, addr_d;
    logic [LengthBits-1:0] remain_q, remain_d;
    logic [4:0]            burst_q, burst_d;
    logic [3:0]            beat_q, beat_d;
    logic                  awvalid_q, awvalid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            err_q, err_d;

    logic [4:0] blen;
    logic       last_beat;
    logic       w_hs;
    logic       unused_bid;

    dma_burst_len #(
        .DataBits   (DataBits),
        .LengthBits (LengthBits)
    ) u_burst_len (
        .clk     (clk),
        .rst     (rst),
        .calc    (state_q == ST_CALC),
        .addr_lo (addr_q[11:0]),
        .remain  (remain_q),
        .burst   (burst_q),
        .blen    (blen)
    );

    assign last_beat  = (beat_q == 4'(blen - 5'd1));
    assign w_hs       = (state_q == ST_DATA) && din_valid && mst_wready;
    assign unused_bid = ^mst_bid;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        awvalid_d = awvalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    addr_d   = cfg_dest;
                    remain_d = cfg_len;
                    burst_d  = clamp_burst(cfg_burst);
                    err_d    = AXI_RESP_OKAY;
                    beat_d   = '0;
                    // Zero-length transfers complete without touching the bus.
                    if (cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (32'(din_fifo_used) >= 32'(blen)) begin
                    awvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (mst_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    remain_d = remain_q - LengthBits'(1);
                    beat_d   = beat_q + 4'd1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (mst_bvalid) begin
                    if (mst_bresp != AXI_RESP_OKAY && err_q == AXI_RESP_OKAY) begin
                        err_d = mst_bresp;
                    end
                    addr_d = addr_q + (AddrBits'(blen) << SizeLog2);
                    if (remain_q != '0) begin
                        state_d = ST_CALC;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= AXI_RESP_OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            awvalid_q <= awvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cfg_busy   = busy_q;
    assign cfg_done   = done_q;
    assign cfg_remain = remain_q;
    assign cfg_err    = err_q;

    assign mst_awvalid = awvalid_q;
    assign mst_awid    = '0;
    assign mst_awaddr  = addr_q;
    assign mst_awlen   = 4'(blen - 5'd1);
    assign mst_awsize  = 3'(SizeLog2);
    assign mst_awburst = AXI_BURST_INCR;
    assign mst_awlock  = '0;

    // W channel is a straight pass-through of the FIFO handshake while in DATA.
    assign mst_wvalid = (state_q == ST_DATA) && din_valid;
    assign din_ready  = (state_q == ST_DATA) && mst_wready;
    assign mst_wid    = '0;
    assign mst_wdata  = din_data;
    assign mst_wstrb  = '1;
    assign mst_wlast  = (state_q == ST_DATA) && last_beat;
    assign mst_bready = (state_q == ST_RESP);

endmodule

// File: tb/tb_dma_writer.sv
// Directed bench for dma_writer with a FIFO model, an AXI write slave model and transaction logs.
module tb_dma_writer;

    localparam int unsigned DataBits = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_dest;
    logic [15:0] cfg_len;
    logic [4:0]  cfg_burst;
    logic        cfg_valid;
    logic        cfg_busy;
    logic        cfg_done;
    logic [15:0] cfg_remain;
    logic [1:0]  cfg_err;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] din_data;
    logic [6:0]  din_fifo_used;
    logic        mst_awvalid;
    logic        mst_awready;
    logic [3:0]  mst_awid;
    logic [31:0] mst_awaddr;
    logic [3:0]  mst_awlen;
    logic [2:0]  mst_awsize;
    logic [1:0]  mst_awburst;
    logic [1:0]  mst_awlock;
    logic        mst_wvalid;
    logic        mst_wready;
    logic [3:0]  mst_wid;
    logic [63:0] mst_wdata;
    logic [7:0]  mst_wstrb;
    logic        mst_wlast;
    logic        mst_bvalid;
    logic        mst_bready;
    logic [3:0]  mst_bid;
    logic [1:0]  mst_bresp;

    always #5 clk = ~clk;

    dma_writer #(
        .DataBits     (DataBits),
        .AddrBits     (32),
        .LengthBits   (16),
        .FifoUsedBits (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_dest      (cfg_dest),
        .cfg_len       (cfg_len),
        .cfg_burst     (cfg_burst),
        .cfg_valid     (cfg_valid),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_remain    (cfg_remain),
        .cfg_err       (cfg_err),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .din_data      (din_data),
        .din_fifo_used (din_fifo_used),
        .mst_awvalid   (mst_awvalid),
        .mst_awready   (mst_awready),
        .mst_awid      (mst_awid),
        .mst_awaddr    (mst_awaddr),
        .mst_awlen     (mst_awlen),
        .mst_awsize    (mst_awsize),
        .mst_awburst   (mst_awburst),
        .mst_awlock    (mst_awlock),
        .mst_wvalid    (mst_wvalid),
        .mst_wready    (mst_wready),
        .mst_wid       (mst_wid),
        .mst_wdata     (mst_wdata),
        .mst_wstrb     (mst_wstrb),
        .mst_wlast     (mst_wlast),
        .mst_bvalid    (mst_bvalid),
        .mst_bready    (mst_bready),
        .mst_bid       (mst_bid),
        .mst_bresp     (mst_bresp)
    );

    // FIFO model: stimulus pushes, the DUT pops; occupancy can be overridden.
    logic [63:0] fifo_mem [0:255];
    logic [7:0]  wr_ptr     = '0;
    logic [7:0]  rd_ptr     = '0;
    logic        used_force = 1'b0;
    logic [6:0]  used_val   = '0;

    assign din_valid     = (wr_ptr != rd_ptr);
    assign din_data      = fifo_mem[rd_ptr];
    assign din_fifo_used = used_force ? used_val : 7'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (din_valid && din_ready) rd_ptr <= rd_ptr + 8'd1;
    end

    // AXI slave model.
    logic aw_rdy_en = 1'b1;
    logic w_toggle  = 1'b0;
    logic w_tick    = 1'b0;
    logic bvalid_r  = 1'b0;
    logic [1:0] bresp_r = 2'b00;
    int   err_burst = -1;

    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0;
    logic [31:0] aw_addr_log [0:63];
    logic [3:0]  aw_len_log  [0:63];
    logic [63:0] w_data_log  [0:255];
    logic        w_last_log  [0:255];

    assign mst_awready = aw_rdy_en;
    assign mst_wready  = w_toggle ? w_tick : 1'b1;
    assign mst_bvalid  = bvalid_r;
    assign mst_bresp   = bresp_r;
    assign mst_bid     = 4'd0;

    always @(posedge clk) w_tick <= ~w_tick;

    always @(posedge clk) begin
        if (rst) begin
            bvalid_r <= 1'b0;
        end else if (mst_wvalid && mst_wready && mst_wlast) begin
            bvalid_r <= 1'b1;
            bresp_r  <= (b_cnt == err_burst) ? 2'b10 : 2'b00;
        end else if (mst_bvalid && mst_bready) begin
            bvalid_r <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (mst_awvalid && mst_awready) begin
            aw_addr_log[aw_cnt] <= mst_awaddr;
            aw_len_log[aw_cnt]  <= mst_awlen;
            aw_cnt              <= aw_cnt + 1;
        end
        if (mst_wvalid && mst_wready) begin
            w_data_log[w_cnt] <= mst_wdata;
            w_last_log[w_cnt] <= mst_wlast;
            w_cnt             <= w_cnt + 1;
        end
        if (mst_bvalid && mst_bready) b_cnt <= b_cnt + 1;
        if (cfg_done) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    int push_k = 0;

    function automatic logic [63:0] pat(input int k);
        return 64'hC0DE_0000_0000_0000 + 64'(k) * 64'h0000_0001_0000_0101;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = pat(push_k);
            wr_ptr = wr_ptr + 8'd1;
            push_k++;
        end
    endtask

    task automatic start(input logic [31:0] d, input logic [15:0] l, input logic [4:0] b);
        cfg_dest  = d;
        cfg_len   = l;
        cfg_burst = b;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && cfg_done !== 1'b1; i++) @(negedge clk);
        check({tag, "_done_seen"}, cfg_done, 1'b1);
        check({tag, "_busy_at_done"}, cfg_busy, 1'b0);
        check({tag, "_remain_at_done"}, cfg_remain, 16'd0);
    endtask

    task automatic check_aw(input string tag, input int idx, input logic [31:0] a, input logic [3:0] l);
        check({tag, "_awaddr"}, aw_addr_log[idx], a);
        check({tag, "_awlen"}, aw_len_log[idx], l);
    endtask

    task automatic check_data(input string tag, input int w0, input int k0, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_wdata"}, w_data_log[w0 + i], pat(k0 + i));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int aw0, w0, b0, d0, k0;

        rst       = 1'b1;
        cfg_dest  = '0;
        cfg_len   = '0;
        cfg_burst = '0;
        cfg_valid = 1'b0;
        tick(3);
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_done", cfg_done, 1'b0);
        check("rst_remain", cfg_remain, 16'd0);
        check("rst_err", cfg_err, 2'b00);
        check("rst_awvalid", mst_awvalid, 1'b0);
        check("rst_wvalid", mst_wvalid, 1'b0);
        check("rst_bready", mst_bready, 1'b0);
        check("rst_din_ready", din_ready, 1'b0);
        check("awsize", mst_awsize, 3'd3);
        check("awburst", mst_awburst, 2'b01);
        check("wstrb", mst_wstrb, 8'hFF);
        rst = 1'b0;
        tick(2);

        // Two full 16-beat bursts.
        aw0 = aw_cnt; w0 = w_cnt; d0 = done_cnt; k0 = push_k;
        push_words(32);
        start(32'h1000, 16'd32, 5'd16);
        check("t1_busy", cfg_busy, 1'b1);
        check("t1_remain_start", cfg_remain, 16'd32);
        wait_done("t1", 400);
        tick(3);
        check("t1_aw_count", aw_cnt - aw0, 2);
        check_aw("t1_b0", aw0, 32'h1000, 4'd15);
        check_aw("t1_b1", aw0 + 1, 32'h1080, 4'd15);
        check("t1_w_count", w_cnt - w0, 32);
        for (int i = 0; i < 32; i++) check("t1_wlast", w_last_log[w0 + i], (i == 15 || i == 31));
        check_data("t1", w0, k0, 32);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_done_low", cfg_done, 1'b0);

        // Remain-limited tail burst.
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; k0 = push_k;
        push_words(20);
        start(32'h0, 16'd20, 5'd8);
        wait_done("t2", 400);
        check("t2_aw_count", aw_cnt - aw0, 3);
        check_aw("t2_b0", aw0, 32'h00, 4'd7);
        check_aw("t2_b1", aw0 + 1, 32'h40, 4'd7);
        check_aw("t2_b2", aw0 + 2, 32'h80, 4'd3);
        check("t2_b_count", b_cnt - b0, 3);
        check_data("t2", w0, k0, 20);

        // 4 KB boundary split.
        aw0 = aw_cnt; w0 = w_cnt; k0 = push_k;
        push_words(16);
        start(32'h0FE0, 16'd16, 5'd16);
        wait_done("t3", 400);
        check("t3_aw_count", aw_cnt - aw0, 2);
        check_aw("t3_b0", aw0, 32'h0FE0, 4'd3);
        check_aw("t3_b1", aw0 + 1, 32'h1000, 4'd11);
        check_data("t3", w0, k0, 16);

        // FIFO-level gating, AW backpressure, W backpressure.
        aw0 = aw_cnt; w0 = w_cnt; k0 = push_k;
        push_words(8);
        used_force = 1'b1;
        used_val   = 7'd3;
        aw_rdy_en  = 1'b0;
        start(32'h2000, 16'd8, 5'd4);
        for (int i = 0; i < 10; i++) begin
            check("t4_gated_awvalid", mst_awvalid, 1'b0);
            tick(1);
        end
        used_val = 7'd4;
        tick(1);
        check("t4_awvalid_rise", mst_awvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t4_hold_awvalid", mst_awvalid, 1'b1);
            check("t4_hold_awaddr", mst_awaddr, 32'h2000);
            check("t4_hold_awlen", mst_awlen, 4'd3);
        end
        aw_rdy_en  = 1'b1;
        used_force = 1'b0;
        w_toggle   = 1'b1;
        wait_done("t4", 400);
        w_toggle   = 1'b0;
        check("t4_aw_count", aw_cnt - aw0, 2);
        check_aw("t4_b0", aw0, 32'h2000, 4'd3);
        check_aw("t4_b1", aw0 + 1, 32'h2020, 4'd3);
        check("t4_w_count", w_cnt - w0, 8);
        check_data("t4", w0, k0, 8);

        // Error response on first burst only.
        aw0 = aw_cnt; b0 = b_cnt; d0 = done_cnt;
        push_words(32);
        err_burst = b_cnt;
        start(32'h3000, 16'd32, 5'd16);
        for (int i = 0; i < 400 && b_cnt == b0; i++) @(negedge clk);
        check("t5_first_b_seen", b_cnt - b0, 1);
        check("t5_err_after_first", cfg_err, 2'b10);
        check("t5_busy_after_first", cfg_busy, 1'b1);
        wait_done("t5", 400);
        err_burst = -1;
        check("t5_err_final", cfg_err, 2'b10);
        check("t5_aw_count", aw_cnt - aw0, 2);
        check("t5_b_count", b_cnt - b0, 2);

        // Zero length: immediate done, clears error, no AW.
        aw0 = aw_cnt;
        start(32'h4000, 16'd0, 5'd4);
        check("t6_done", cfg_done, 1'b1);
        check("t6_err_cleared", cfg_err, 2'b00);
        check("t6_awvalid", mst_awvalid, 1'b0);
        tick(1);
        check("t6_done_low", cfg_done, 1'b0);
        tick(3);
        check("t6_aw_count", aw_cnt - aw0, 0);

        // Reset mid-DATA, then a clean transfer.
        push_words(16);
        start(32'h5000, 16'd16, 5'd16);
        for (int i = 0; i < 100 && mst_wvalid !== 1'b1; i++) @(negedge clk);
        check("t7_reached_data", mst_wvalid, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("t7_rst_busy", cfg_busy, 1'b0);
        check("t7_rst_remain", cfg_remain, 16'd0);
        check("t7_rst_wvalid", mst_wvalid, 1'b0);
        check("t7_rst_din_ready", din_ready, 1'b0);
        check("t7_rst_awvalid", mst_awvalid, 1'b0);
        check("t7_rst_bready", mst_bready, 1'b0);
        check("t7_rst_done", cfg_done, 1'b0);
        rst    = 1'b0;
        wr_ptr = rd_ptr;
        tick(2);
        aw0 = aw_cnt; w0 = w_cnt; k0 = push_k;
        push_words(8);
        start(32'h6000, 16'd8, 5'd0);
        wait_done("t7", 400);
        check("t7_aw_count", aw_cnt - aw0, 1);
        check_aw("t7_b0", aw0, 32'h6000, 4'd7);
        check("t7_w_count", w_cnt - w0, 8);
        check("t7_wlast", w_last_log[w0 + 7], 1'b1);
        check_data("t7", w0, k0, 8);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
